// File: rtl/capture_sequencer.sv
// capture_sequencer: arms on a software command and forwards only whole camera frames,
// checking the geometry of every forwarded frame against WIDTH x HEIGHT.
module capture_sequencer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 512,
    parameter int DATA_WIDTH = 12,
    parameter int FCNT_W     = 8
) (
    input  logic                  pix_clk,
    input  logic                  rstb,
    input  logic                  cmd_start,
    input  logic                  cmd_abort,
    input  logic [FCNT_W-1:0]     cmd_nframes,
    input  logic                  in_fval,
    input  logic                  in_lval,
    input  logic                  in_dval,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_fval,
    output logic                  out_lval,
    output logic                  out_dval,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic [FCNT_W-1:0]     frames_done,
    output logic [15:0]           meas_lines,
    output logic                  geom_err
);
    typedef enum logic [1:0] {IDLE, WAIT_GAP, WAIT_FRAME, CAPTURE} state_t;
    state_t state;
    logic [FCNT_W-1:0] nframes, frames_next;
    logic abort_pending, pass, pix, line_close, line_ok, frame_end, last_frame;
    logic [15:0] pix_cnt, line_cnt, lines_total;

    assign pass = (state == WAIT_FRAME && in_fval) || state == CAPTURE;
    assign pix = pass && in_fval && in_lval && in_dval;
    // out_lval is exactly the forwarded lval of the previous cycle
    assign line_close = pass && out_lval && !(in_fval && in_lval);
    assign line_ok = line_close && pix_cnt != '0;
    assign frame_end = state == CAPTURE && !in_fval;
    assign lines_total = line_cnt + {15'd0, line_ok};
    assign frames_next = frames_done + FCNT_W'(1);
    assign last_frame = nframes != '0 && frames_next == nframes;
    assign busy = state != IDLE;

    always_ff @(posedge pix_clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            nframes <= '0;
            abort_pending <= 1'b0;
            pix_cnt <= '0;
            line_cnt <= '0;
            out_fval <= 1'b0;
            out_lval <= 1'b0;
            out_dval <= 1'b0;
            out_data <= '0;
            done <= 1'b0;
            frames_done <= '0;
            meas_lines <= '0;
            geom_err <= 1'b0;
        end else begin
            out_fval <= pass && in_fval;
            out_lval <= pass && in_fval && in_lval;
            out_dval <= pix;
            out_data <= pix ? in_data : '0;
            done <= 1'b0;
            if (pix && pix_cnt != 16'hFFFF)
                pix_cnt <= pix_cnt + 16'd1;
            if (line_close) begin
                pix_cnt <= '0;
                if (line_ok) begin
                    line_cnt <= line_cnt + 16'd1;
                    if (pix_cnt != 16'(WIDTH))
                        geom_err <= 1'b1;
                end
            end
            if (frame_end) begin
                pix_cnt <= '0;
                line_cnt <= '0;
                meas_lines <= lines_total;
                frames_done <= frames_next;
                if (lines_total != 16'(HEIGHT))
                    geom_err <= 1'b1;
            end
            case (state)
                IDLE: if (cmd_start && !cmd_abort) begin
                    nframes <= cmd_nframes;
                    frames_done <= '0;
                    geom_err <= 1'b0;
                    abort_pending <= 1'b0;
                    pix_cnt <= '0;
                    line_cnt <= '0;
                    state <= in_fval ? WAIT_GAP : WAIT_FRAME;
                end
                WAIT_GAP: state <= cmd_abort ? IDLE : in_fval ? WAIT_GAP : WAIT_FRAME;
                WAIT_FRAME: state <= cmd_abort ? IDLE : in_fval ? CAPTURE : WAIT_FRAME;
                CAPTURE: if (frame_end) begin
                    abort_pending <= 1'b0;
                    if (abort_pending || cmd_abort)
                        state <= IDLE;
                    else if (last_frame) begin
                        state <= IDLE;
                        done <= 1'b1;
                    end else
                        state <= WAIT_FRAME;
                end else if (cmd_abort)
                    abort_pending <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: command vectors, directed frame scenarios and random traffic
// checked against a frame-level model of which frames get forwarded.
module tb_capture_sequencer;
    localparam int W = 4, H = 3, DW = 12, FW = 8;
    logic pix_clk = 1'b0, rstb = 1'b0, cmd_start = 1'b0, cmd_abort = 1'b0;
    logic [FW-1:0] cmd_nframes = '0;
    logic in_fval = 1'b0, in_lval = 1'b0, in_dval = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic out_fval, out_lval, out_dval, busy, done, geom_err;
    logic [DW-1:0] out_data;
    logic [FW-1:0] frames_done;
    logic [15:0] meas_lines;
    int n_chk = 0, n_fail = 0;

    // frame-level model: run active, current frame blocked/forwarded, abort pending
    bit act = 0, blk = 0, infwd = 0, pend = 0, done_e = 0, err_e = 0, pf = 0, fr_err = 0;
    int nfr = 0, fd = 0, meas = 0, fr_lines = 0;
    int wl[6];

    typedef struct {
        bit cs, ca;
        int n;
        bit f, l, d;
        bit busy_e, fval_e;
    } vec_t;
    vec_t tv[15];

    capture_sequencer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .FCNT_W(FW)) dut (
        .pix_clk(pix_clk), .rstb(rstb), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cmd_nframes(cmd_nframes), .in_fval(in_fval), .in_lval(in_lval), .in_dval(in_dval),
        .in_data(in_data), .out_fval(out_fval), .out_lval(out_lval), .out_dval(out_dval),
        .out_data(out_data), .busy(busy), .done(done), .frames_done(frames_done),
        .meas_lines(meas_lines), .geom_err(geom_err)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input bit f, input bit l, input bit d, input bit cs = 1'b0,
                        input bit ca = 1'b0, input int n = 0);
        logic [DW-1:0] dat;
        bit fw;
        dat = DW'($urandom);
        in_fval = f; in_lval = l; in_dval = d; in_data = dat;
        cmd_start = cs; cmd_abort = ca; cmd_nframes = FW'(n);
        done_e = 0;
        if (cs && !ca && !act) begin
            act = 1; nfr = n; fd = 0; err_e = 0; pend = 0; blk = f;
        end else if (ca && act) begin
            if (infwd) pend = 1; else act = 0;
        end
        if (f && !pf) infwd = act && !blk;
        if (!f && pf) begin
            if (infwd) begin
                fd = (fd + 1) % 256;
                meas = fr_lines;
                err_e = err_e | fr_err;
                if (pend) act = 0;
                else if (nfr != 0 && fd == nfr) begin act = 0; done_e = 1; end
                pend = 0;
            end
            infwd = 0; blk = 0;
        end
        fw = infwd && f;
        pf = f;
        @(posedge pix_clk); #1;
        chk("out", {out_fval, out_lval, out_dval, out_data},
            {fw, fw & l, fw & l & d, (fw & l & d) ? dat : 12'h0});
        chk("busy", busy, act);
        chk("done", done, done_e);
        chk("frames_done", frames_done, fd);
        chk("meas_lines", meas_lines, meas);
        if (!fw) chk("geom_err", geom_err, err_e);
        cmd_start = 0; cmd_abort = 0;
    endtask

    task automatic gap(input int len, input bit cs = 1'b0, input bit ca = 1'b0, input int n = 0);
        for (int i = 0; i < len; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 0 && cs, i == 0 && ca, n);
    endtask

    // lines take their dval counts from wl[]; a zero entry is an lval with no dval
    task automatic frame(input int nl, input bit tail, input int cl = -1, input bit cs = 1'b0,
                         input bit ca = 1'b0, input int n = 0);
        int cnt = 0;
        bit e = 0;
        for (int i = 0; i < nl; i++)
            if (wl[i] != 0) begin cnt++; if (wl[i] != W) e = 1; end
        fr_lines = cnt;
        fr_err = e || cnt != H;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nl; i++) begin
            bit c = (i == cl);
            int bub = (wl[i] > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, wl[i] - 1)) : -1;
            int len = (wl[i] == 0) ? 2 : wl[i] + (bub >= 0 ? 1 : 0);
            for (int k = 0; k < len; k++)
                step(1'b1, 1'b1, wl[i] != 0 && k != bub, c && k == 0 && cs, c && k == 0 && ca, n);
            if (!(tail && i == nl - 1)) step(1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic good();
        wl = '{W, W, W, 0, 0, 0};
    endtask

    initial begin
        tv[0]  = '{1, 1, 2, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 1, 1, 1, 0, 0};
        tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[3]  = '{1, 0, 2, 0, 0, 0, 1, 0};
        tv[4]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 0, 1, 1, 1, 0, 0};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[7]  = '{1, 0, 1, 1, 0, 0, 1, 0};
        tv[8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
        tv[9]  = '{0, 1, 0, 1, 0, 0, 0, 0};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[11] = '{1, 0, 1, 0, 0, 0, 1, 0};
        tv[12] = '{0, 0, 0, 1, 1, 1, 1, 1};
        tv[13] = '{0, 1, 0, 1, 0, 0, 1, 1};
        tv[14] = '{0, 0, 0, 0, 0, 0, 0, 0};

        repeat (2) @(posedge pix_clk);
        #1;
        chk("reset_out", {out_fval, out_lval, out_dval, out_data, busy, done}, 0);
        chk("reset_status", {frames_done, meas_lines, geom_err}, 0);
        rstb = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cmd_start = tv[i].cs; cmd_abort = tv[i].ca; cmd_nframes = FW'(tv[i].n);
            in_fval = tv[i].f; in_lval = tv[i].l; in_dval = tv[i].d; in_data = DW'(i);
            @(posedge pix_clk); #1;
            chk($sformatf("vec%0d", i), {busy, out_fval, done}, {tv[i].busy_e, tv[i].fval_e, 1'b0});
        end
        cmd_start = 0; cmd_abort = 0;
        chk("vec_status", {frames_done, meas_lines, geom_err}, {8'd1, 16'd1, 1'b1});
        fd = 1; meas = 1; err_e = 1;

        good();
        gap(3, 1, 0, 1); frame(3, 0);
        chk("single_status", {frames_done, meas_lines, geom_err}, {8'd1, 16'd3, 1'b0});
        gap(2); frame(3, 0);
        gap(2); frame(3, 0, 1, 1, 0, 1); gap(1); frame(3, 0); gap(2);
        gap(2, 1, 0, 3); frame(3, 0); gap(2, 1, 0, 7); frame(3, 1); gap(1);
        frame(3, 0); gap(1); frame(3, 0); gap(2);
        chk("multi_frames", frames_done, 3);
        gap(2, 1, 0, 0);
        for (int i = 0; i < 257; i++) begin frame(3, 0); gap(1); end
        chk("cont_frames", {frames_done, busy}, {8'd1, 1'b1});
        gap(2, 0, 1);
        wl[1] = 3;
        gap(2, 1, 0, 1); frame(3, 0);
        chk("short_line", {meas_lines, geom_err}, {16'd3, 1'b1});
        good();
        gap(2, 1, 0, 1); frame(2, 0);
        chk("two_lines", {meas_lines, geom_err}, {16'd2, 1'b1});
        gap(2); gap(2, 1, 0, 1); gap(1, 0, 1);
        chk("err_cleared", geom_err, 0);
        gap(2, 1, 0, 2); frame(3, 0, 1, 0, 1);
        chk("abort_capture", {frames_done, busy}, {8'd1, 1'b0});
        gap(2);
        wl = '{W, 0, W, W, 0, 0};
        gap(2, 1, 0, 1); frame(4, 1); gap(2);

        for (int it = 0; it < 60; it++) begin
            int r = $urandom_range(0, 9);
            int r2 = $urandom_range(0, 9);
            int nl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : H;
            gap($urandom_range(1, 3), r < 4, r == 4, $urandom_range(0, 3));
            for (int i = 0; i < 6; i++)
                wl[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : W;
            frame(nl, 1'($urandom_range(0, 1)), $urandom_range(0, nl - 1), r2 < 2, r2 == 2,
                  $urandom_range(0, 3));
        end
        gap(3, 0, 1);

        good();
        gap(2, 1, 0, 0);
        step(1, 0, 0); step(1, 1, 1); step(1, 1, 1);
        #2 rstb = 1'b0;
        #1;
        chk("async_reset_out", {out_fval, out_lval, out_dval, out_data, busy, done}, 0);
        chk("async_reset_status", {frames_done, meas_lines, geom_err}, 0);
        @(posedge pix_clk); #1;
        rstb = 1'b1;
        act = 0; fd = 0; meas = 0; err_e = 0; infwd = 0; blk = 0; pend = 0;
        step(1, 1, 1); step(1, 0, 0); step(0, 0, 0);
        gap(2); frame(3, 0); gap(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Frame-capture controller sitting between the Camera Link receive interface and the frame grabber/dump stage. Software arms it for N whole frames (or continuous capture), and it forwards only complete frames, gated strictly on frame boundaries. Each forwarded frame's geometry is checked against WIDTH×HEIGHT, and the block reports frame count, completion and errors.

## Interface
- WIDTH, 640, expected dval pixels per line
- HEIGHT, 512, expected lines per frame
- DATA_WIDTH, 12, pixel bus width
- FCNT_W, 8, width of frame-count command/status
- pix_clk  in  1  pixel clock, all logic on rising edge
- rstb  in  1  asynchronous, active-low reset
- cmd_start  in  1  one-cycle pulse: arm capture
- cmd_abort  in  1  one-cycle pulse: stop after current frame
- cmd_nframes  in  FCNT_W  frames to capture, sampled on accepted cmd_start; 0 = continuous
- in_fval, in_lval, in_dval  in  1 each  camera timing
- in_data  in  DATA_WIDTH  camera pixel
- out_fval, out_lval, out_dval  out  1 each  gated, registered timing to grabber
- out_data  out  DATA_WIDTH  registered pixel
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal completion
- frames_done  out  FCNT_W  frames forwarded since last accepted start, wraps
- meas_lines  out  16  lines counted in last forwarded frame
- geom_err  out  1  sticky geometry mismatch, cleared by accepted cmd_start

## Operation
- States: IDLE, WAIT_GAP, WAIT_FRAME, CAPTURE.
- IDLE: cmd_start && !cmd_abort is accepted. Accepting it latches cmd_nframes, clears frames_done, geom_err and abort_pending, then goes to WAIT_GAP if in_fval=1, else WAIT_FRAME. cmd_start is ignored when busy. Start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- WAIT_GAP: in_fval=0 -> WAIT_FRAME. This prevents forwarding a partial frame.
- WAIT_FRAME: in_fval=1 -> CAPTURE. This cycle already passes data.
- CAPTURE: in_fval=0 is frame end. On frame end, frames_done+1 and meas_lines is updated.
  - abort_pending -> IDLE, with no done.
  - Else if nframes!=0 and frames_done+1==nframes -> IDLE, with done pulse.
  - Else -> WAIT_FRAME.
- cmd_abort:
  - In WAIT_GAP or WAIT_FRAME: immediate -> IDLE, no done.
  - In CAPTURE: sets abort_pending; the frame completes.
  - In IDLE: no effect.
- pass = (state==WAIT_FRAME && in_fval) || state==CAPTURE.
- Output registers:
  - out_fval <= pass & in_fval
  - out_lval <= pass & in_fval & in_lval
  - out_dval <= pass & in_fval & in_lval & in_dval
  - out_data <= out_dval-condition ? in_data : 0
- Geometry, counted only while pass:
  - pix_cnt (16 b, saturating at FFFF) counts in_lval&in_dval cycles.
  - Line close is lval falling (prev_lval & !in_lval) or frame end with prev_lval=1.
  - On line close with pix_cnt>0: line_cnt+1. If pix_cnt!=WIDTH, set geom_err. Then clear pix_cnt.
  - Lines with zero dval are not counted.
  - On frame end: meas_lines<=line_cnt, counting the line closed in that same cycle. If that count != HEIGHT, set geom_err. Clear line_cnt.
- Continuous mode: frames_done wraps 2^FCNT_W-1 -> 0; done is never asserted.

## Timing
- Reset: state IDLE; all outputs 0, including meas_lines, frames_done and geom_err; internal counters and abort_pending 0.
- Data latency in to out: 1 cycle. Output waveform equals input waveform delayed by 1 cycle for every forwarded frame.
- busy rises the cycle after accepted cmd_start. It falls the cycle after the frame-end cycle that ends the run.
- done, frames_done and meas_lines update on the edge that samples the frame-end cycle (in_fval=0). They are visible together with out_fval=0.
- Reset mid-frame: outputs drop to 0 asynchronously. After release the block sits in IDLE and requires a new cmd_start.
- in_lval/in_dval while in_fval=0 are never forwarded or counted.

## Test plan
All scenarios use WIDTH=4 and HEIGHT=3.
- Single frame: nframes=1; start during fval=0; frame of 3 lines × 4 dval -> out identical and delayed 1 cycle; frames_done=1, meas_lines=3, geom_err=0, done pulses once, busy then 0; a following frame is not forwarded.
- Mid-frame start: cmd_start while in_fval=1 -> current frame blocked (out_fval stays 0); next frame forwarded intact.
- Multi/continuous: nframes=3 -> exactly 3 frames forwarded, done after third. nframes=0 with 257 frames (FCNT_W=8) -> frames_done=1, no done.
- Geometry errors: one line with 3 dval -> geom_err=1, meas_lines=3. A separate frame of 2 lines -> geom_err=1, meas_lines=2. Then cmd_start clears geom_err.
- Abort: abort in WAIT_FRAME -> IDLE next cycle, no output. Abort mid-CAPTURE -> frame completes fully, IDLE, done=0, frames_done=1.
- Edge cases:
  - start+abort same cycle -> stays IDLE.
  - cmd_start while busy -> ignored, nframes unchanged.
  - rstb low mid-line -> all outputs 0 immediately.
